// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_FIXED  = 2'b01,
        MODE_RR     = 2'b10
    } mode_t;

    // Channel-index width for an n-channel mux.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Picks one requesting channel by manual select, fixed priority or round-robin.
// Latency: combinational grant; last_grant updates on the edge after an advance.
// Backpressure: none here; the caller qualifies advance with its own load enable.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N-1:0]            req,
    input  mode_t                   mode,
    input  logic [idx_w(N)-1:0]     sel,
    input  logic                    advance,
    output logic [idx_w(N)-1:0]     grant,
    output logic                    grant_valid
);
    localparam int SW = idx_w(N);
    localparam int PW = 2 ** SW;

    logic [SW-1:0] last_grant;
    logic [PW-1:0] req_pad;

    // Padding lets sel address indices >= N safely; those lanes never request.
    assign req_pad = PW'(req);

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        case (mode)
            MODE_FIXED: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        grant       = SW'(i);
                        grant_valid = 1'b1;
                    end
                end
            end
            MODE_RR: begin
                // Descending scan so the nearest channel after last_grant wins.
                for (int k = N; k >= 1; k--) begin
                    if (req[(int'(last_grant) + k) % N]) begin
                        grant       = SW'((int'(last_grant) + k) % N);
                        grant_valid = 1'b1;
                    end
                end
            end
            default: begin
                if ((int'(sel) < N) && req_pad[sel]) begin
                    grant       = sel;
                    grant_valid = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= SW'(N - 1);
        end else if (advance && (mode == MODE_RR)) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream mux with a single registered output stage.
// Latency: one clock from input acceptance to out_valid; full throughput.
// Backpressure: in_ready all-0 while the output word is stalled or during reset.
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  mode_t                       mode,
    input  logic [idx_w(N)-1:0]         sel,
    input  logic [N-1:0][WIDTH-1:0]     in_data,
    input  logic [N-1:0]                in_valid,
    output logic [N-1:0]                in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [idx_w(N)-1:0]         out_chan
);
    localparam int SW = idx_w(N);

    logic [SW-1:0] grant;
    logic          grant_valid;
    logic          load_en;
    logic          xfer;

    assign load_en = !out_valid || out_ready;
    // A grant already implies in_valid[grant], so the handshake reduces to this.
    assign xfer    = !reset && load_en && grant_valid;

    assign in_ready = xfer ? (N'(1) << grant) : '0;

    rr_arbiter #(.N(N)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (in_valid),
        .mode        (mode),
        .sel         (sel),
        .advance     (xfer),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant];
            out_chan  <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
